// File: rtl/cpu_result_sink_if.sv
// ============================================================================
// Module   : cpu_result_sink_if
// Brief    : CPU result stream handshake bundle (cpu = master, sink = slave)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_result_sink_if;
    logic       next_out;
    logic       data_out;
    logic       result_ready;
    logic [7:0] opcode;
    logic [7:0] operand_A;
    logic [7:0] operand_B;
    logic [7:0] result;
    logic       carry;
    logic       borrow;
    logic [7:0] pc;

    modport master (
        input  next_out,
        output data_out, result_ready, opcode, operand_A, operand_B,
               result, carry, borrow, pc
    );

    modport slave (
        output next_out,
        input  data_out, result_ready, opcode, operand_A, operand_B,
               result, carry, borrow, pc
    );
endinterface

`default_nettype wire

// File: rtl/cpu_result_sink.sv
// ============================================================================
// Module   : cpu_result_sink
// Brief    : Requests CPU result records, buffers them in a FIFO and flags
//            dropped offers and PC-sequence breaks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_result_sink #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int RECW  = 42
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    cpu_result_sink_if.slave      s_cpu,
    input  wire logic             i_enable,
    input  wire logic             i_rd_en,
    output logic                  o_rd_valid,
    output logic [RECW-1:0]       o_rd_data,
    output logic [AW:0]           o_count,
    output logic                  o_overflow,
    output logic                  o_pc_skip
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW:0]   c_almost  = c_full - c_cnt_one;
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    state_t            r_state;
    logic              r_next_out;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [RECW-1:0]   r_mem [DEPTH];
    logic              r_rd_valid;
    logic [RECW-1:0]   r_rd_data;
    logic              r_overflow;
    logic              r_pc_skip;
    logic              r_first;
    logic [7:0]        r_last_pc;

    logic              w_offer;
    logic              w_cap;
    logic              w_pop;
    logic              w_full;
    logic              w_wr;
    logic              w_bypass;
    logic [AW:0]       w_count_nxt;
    logic [AW:0]       w_count_after_pop;
    logic [AW-1:0]     w_rd_ptr_nxt;
    logic [RECW-1:0]   w_rec;

    assign w_offer = s_cpu.data_out & s_cpu.result_ready;
    assign w_cap   = r_next_out & w_offer;
    assign w_pop   = i_rd_en & r_rd_valid;
    assign w_full  = (r_count == c_full);
    assign w_wr    = w_cap & (~w_full | w_pop);
    assign w_rec   = {s_cpu.pc, s_cpu.opcode, s_cpu.operand_A, s_cpu.operand_B,
                      s_cpu.result, s_cpu.carry, s_cpu.borrow};

    always_comb begin
        w_count_nxt       = r_count;
        w_rd_ptr_nxt      = r_rd_ptr;
        w_count_after_pop = r_count;
        if (w_pop) begin
            w_rd_ptr_nxt      = r_rd_ptr + c_ptr_one;
            w_count_after_pop = r_count - c_cnt_one;
        end
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - c_cnt_one;
        end
        // New head is the incoming record when nothing older remains after the pop
        w_bypass = w_wr && (w_count_after_pop == '0);
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= (w_count_nxt != '0);
            if (w_bypass) begin
                r_rd_data <= w_rec;
            end else if (w_count_nxt != '0) begin
                r_rd_data <= r_mem[w_rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_next_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        if (r_count < c_full) begin
                            r_state    <= S_ARMED;
                            r_next_out <= 1'b1;
                        end else begin
                            r_state    <= S_HOLD;
                            r_next_out <= 1'b0;
                        end
                    end
                end
                S_ARMED: begin
                    if (!i_enable) begin
                        r_state    <= S_IDLE;
                        r_next_out <= 1'b0;
                    end else if (w_wr && !w_pop && (r_count == c_almost)) begin
                        r_state    <= S_HOLD;
                        r_next_out <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!i_enable) begin
                        r_state    <= S_IDLE;
                        r_next_out <= 1'b0;
                    end else if (r_count < c_full) begin
                        r_state    <= S_ARMED;
                        r_next_out <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_next_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_pc_skip  <= 1'b0;
            r_first    <= 1'b1;
            r_last_pc  <= '0;
        end else begin
            if (w_offer && !r_next_out) begin
                r_overflow <= 1'b1;
            end
            if (w_cap) begin
                if (!r_first && (s_cpu.pc != r_last_pc + 8'd1)) begin
                    r_pc_skip <= 1'b1;
                end
                r_first   <= 1'b0;
                r_last_pc <= s_cpu.pc;
            end
        end
    end

    assign s_cpu.next_out = r_next_out;
    assign o_rd_valid     = r_rd_valid;
    assign o_rd_data      = r_rd_data;
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_pc_skip      = r_pc_skip;

endmodule

`default_nettype wire

// File: tb/tb_cpu_result_sink.sv
// ============================================================================
// Module   : tb_cpu_result_sink
// Brief    : Directed table-driven bench for cpu_result_sink
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_result_sink;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        rd_en;
    logic        rd_valid;
    logic [41:0] rd_data;
    logic [3:0]  count;
    logic        overflow;
    logic        pc_skip;

    int checks   = 0;
    int failures = 0;

    cpu_result_sink_if u_if ();

    cpu_result_sink #(.DEPTH(8), .AW(3), .RECW(42)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_cpu      (u_if),
        .i_enable   (enable),
        .i_rd_en    (rd_en),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_count    (count),
        .o_overflow (overflow),
        .o_pc_skip  (pc_skip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       dout;
        logic       rdy;
        logic       rd;
        logic [7:0] pc;
        logic       e_no;
        logic       e_rv;
        logic [3:0] e_cnt;
        logic       e_ov;
        logic       e_skip;
        logic [7:0] e_head;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [41:0] pack(input logic [7:0] p, input logic [7:0] op,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] r, input logic c,
                                         input logic bw);
        return {p, op, a, b, r, c, bw};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic rv, input logic [7:0] p);
        u_if.data_out     = dv;
        u_if.result_ready = rv;
        u_if.pc           = p;
        u_if.opcode       = 8'h01;
        u_if.operand_A    = 8'd5;
        u_if.operand_B    = 8'd3;
        u_if.result       = 8'd8;
        u_if.carry        = 1'b0;
        u_if.borrow       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        rd_en  = 1'b0;
        drive(1'b0, 1'b0, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_next_out"}, 64'(u_if.next_out), 64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"},  64'(rd_data), 64'd0);
        chk({tag, "_count"},    64'(count), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_pc_skip"},  64'(pc_skip), 64'd0);
    endtask

    initial begin
        //         en dout rdy rd  pc     no rv cnt ov skip head
        tbl[0]  = '{1, 0, 0, 0, 8'd0,  1, 0, 4'd0, 0, 0, 8'd0};
        tbl[1]  = '{1, 1, 1, 0, 8'd0,  1, 1, 4'd1, 0, 0, 8'd0};
        tbl[2]  = '{1, 1, 1, 0, 8'd1,  1, 1, 4'd2, 0, 0, 8'd0};
        tbl[3]  = '{1, 1, 1, 0, 8'd2,  1, 1, 4'd3, 0, 0, 8'd0};
        tbl[4]  = '{1, 1, 1, 0, 8'd3,  1, 1, 4'd4, 0, 0, 8'd0};
        tbl[5]  = '{1, 0, 0, 1, 8'd0,  1, 1, 4'd3, 0, 0, 8'd1};
        tbl[6]  = '{1, 0, 0, 1, 8'd0,  1, 1, 4'd2, 0, 0, 8'd2};
        tbl[7]  = '{1, 0, 0, 1, 8'd0,  1, 1, 4'd1, 0, 0, 8'd3};
        tbl[8]  = '{1, 0, 0, 1, 8'd0,  1, 0, 4'd0, 0, 0, 8'd0};
        tbl[9]  = '{1, 1, 0, 0, 8'd9,  1, 0, 4'd0, 0, 0, 8'd0};
        tbl[10] = '{1, 1, 0, 0, 8'd9,  1, 0, 4'd0, 0, 0, 8'd0};
        tbl[11] = '{1, 1, 0, 0, 8'd9,  1, 0, 4'd0, 0, 0, 8'd0};
        tbl[12] = '{1, 1, 1, 1, 8'd4,  1, 1, 4'd1, 0, 0, 8'd4};
        tbl[13] = '{1, 0, 0, 1, 8'd0,  1, 0, 4'd0, 0, 0, 8'd0};
        tbl[14] = '{0, 0, 0, 0, 8'd0,  0, 0, 4'd0, 0, 0, 8'd0};

        do_reset();
        chk_idle_outputs("reset");

        // Basic ordered flow, ignored unsettled offers, empty cap+pop, disable
        for (int i = 0; i < 15; i++) begin
            enable = tbl[i].en;
            rd_en  = tbl[i].rd;
            drive(tbl[i].dout, tbl[i].rdy, tbl[i].pc);
            tick();
            chk($sformatf("v%0d_next_out", i), 64'(u_if.next_out), 64'(tbl[i].e_no));
            chk($sformatf("v%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rv));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'(tbl[i].e_ov));
            chk($sformatf("v%0d_pc_skip", i), 64'(pc_skip), 64'(tbl[i].e_skip));
            if (tbl[i].e_rv) begin
                chk($sformatf("v%0d_head_pc", i), 64'(rd_data[41:34]), 64'(tbl[i].e_head));
            end
            if (i == 1) begin
                chk("v1_record", 64'(rd_data), 64'(pack(8'd0, 8'h01, 8'd5, 8'd3, 8'd8, 1'b0, 1'b0)));
            end
        end
        drive(1'b0, 1'b0, 8'd0);
        rd_en = 1'b0;

        // PC wrap is legal, a gap is flagged
        do_reset();
        enable = 1'b1;
        tick();
        drive(1'b1, 1'b1, 8'd254); tick(); chk("wrap_254_skip", 64'(pc_skip), 64'd0);
        drive(1'b1, 1'b1, 8'd255); tick(); chk("wrap_255_skip", 64'(pc_skip), 64'd0);
        drive(1'b1, 1'b1, 8'd0);   tick(); chk("wrap_0_skip", 64'(pc_skip), 64'd0);
        drive(1'b1, 1'b1, 8'd2);   tick(); chk("gap_2_skip", 64'(pc_skip), 64'd1);
        chk("gap_count", 64'(count), 64'd4);
        drive(1'b0, 1'b0, 8'd0);   tick(); chk("skip_sticky", 64'(pc_skip), 64'd1);

        // Fill to DEPTH, then one offer too many
        do_reset();
        enable = 1'b1;
        tick();
        for (int p = 0; p < 8; p++) begin
            drive(1'b1, 1'b1, 8'(p));
            tick();
        end
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_next_out", 64'(u_if.next_out), 64'd0);
        chk("fill_overflow", 64'(overflow), 64'd0);
        drive(1'b1, 1'b1, 8'd8);
        tick();
        chk("ovf_overflow", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_head_pc", 64'(rd_data[41:34]), 64'd0);
        drive(1'b0, 1'b0, 8'd0);

        // Pop from full re-arms, then pop and capture together
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pop1_count", 64'(count), 64'd7);
        chk("pop1_head_pc", 64'(rd_data[41:34]), 64'd1);
        tick();
        chk("rearm_next_out", 64'(u_if.next_out), 64'd1);
        rd_en = 1'b1;
        drive(1'b1, 1'b1, 8'd8);
        u_if.operand_A = 8'hF0;
        u_if.carry     = 1'b1;
        tick();
        drive(1'b0, 1'b0, 8'd0);
        chk("popcap_count", 64'(count), 64'd7);
        chk("popcap_head_pc", 64'(rd_data[41:34]), 64'd2);
        chk("popcap_next_out", 64'(u_if.next_out), 64'd1);
        for (int p = 3; p <= 8; p++) begin
            tick();
            chk($sformatf("drain_pc%0d", p), 64'(rd_data[41:34]), 64'(p));
        end
        chk("tail_record", 64'(rd_data), 64'(pack(8'd8, 8'h01, 8'hF0, 8'd3, 8'd8, 1'b1, 1'b0)));
        tick();
        rd_en = 1'b0;
        chk("drained_valid", 64'(rd_valid), 64'd0);
        chk("drained_count", 64'(count), 64'd0);
        chk("seq_pc_skip", 64'(pc_skip), 64'd0);

        // Asynchronous reset while holding data and sticky flags
        drive(1'b1, 1'b1, 8'd9);
        tick();
        drive(1'b0, 1'b0, 8'd0);
        chk("pre_rst_count", 64'(count), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        tick();
        rst_n  = 1'b1;
        enable = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
